// File: rtl/alu_pkg.sv
// Opcode encodings and legality check shared by the ALU and the arbiter front end.
package alu_pkg;

  typedef logic [3:0] opr_t;

  localparam opr_t OPR_ADD  = 4'b0000;
  localparam opr_t OPR_SUB  = 4'b1000;
  localparam opr_t OPR_SLL  = 4'b0001;
  localparam opr_t OPR_SLT  = 4'b0010;
  localparam opr_t OPR_SLTU = 4'b0011;
  localparam opr_t OPR_XOR  = 4'b0100;
  localparam opr_t OPR_SRL  = 4'b0101;
  localparam opr_t OPR_SRA  = 4'b1101;
  localparam opr_t OPR_OR   = 4'b0110;
  localparam opr_t OPR_AND  = 4'b0111;

  function automatic logic opr_legal(input opr_t opr);
    case (opr)
      OPR_ADD, OPR_SUB, OPR_SLL, OPR_SLT, OPR_SLTU,
      OPR_XOR, OPR_SRL, OPR_SRA, OPR_OR, OPR_AND: opr_legal = 1'b1;
      default:                                     opr_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU; unknown opcodes produce 0.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  opr_t        opr,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (opr)
      OPR_ADD:  result = a + b;
      OPR_SUB:  result = a - b;
      OPR_SLL:  result = a << b[4:0];
      OPR_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      OPR_SLTU: result = {31'b0, a < b};
      OPR_XOR:  result = a ^ b;
      OPR_SRL:  result = a >> b[4:0];
      OPR_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      OPR_OR:   result = a | b;
      OPR_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning from ptr; ptr moves
// past the winner only when the grant is actually consumed (advance).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gidx;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    gidx  = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(gidx) + 1 == NUM_REQ) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ valid/ready requesters with round-robin grant and
// a single registered, ID-tagged response slot (1-cycle latency, 1 op/cycle).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0] req_opr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err,
  output logic [31:0]          ops_done
);

  logic [NUM_REQ-1:0] grant;
  logic               slot_free;
  logic               accept;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  opr_t               sel_opr;
  logic [ID_W-1:0]    sel_id;
  logic [31:0]        alu_result;

  assign slot_free = !rsp_valid || rsp_ready;
  assign req_ready = grant & {NUM_REQ{slot_free && rst_n}};
  assign accept    = |req_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // One-hot AND-OR mux: no priority encoder in the operand path.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_opr = '0;
    sel_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a   |= req_a[32*i +: 32];
        sel_b   |= req_b[32*i +: 32];
        sel_opr |= req_opr[4*i +: 4];
        sel_id   = ID_W'(i);
      end
    end
  end

  alu u_alu (
    .a      (sel_a),
    .b      (sel_b),
    .opr    (sel_opr),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= sel_id;
        rsp_result <= opr_legal(sel_opr) ? alu_result : 32'd0;
        rsp_err    <= !opr_legal(sel_opr);
        ops_done   <= ops_done + 32'd1;
      end else if (rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NUM_REQ=2; inputs change at posedge+1.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_opr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [31:0] ops_done;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opr    (req_opr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] opr);
    req_valid[i]      = v;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_opr[4*i +: 4] = opr;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  tbl_opr [6];
  logic [31:0] tbl_a   [6];
  logic [31:0] tbl_b   [6];
  logic [31:0] tbl_exp [6];

  initial begin
    tbl_opr[0] = OPR_SLL; tbl_a[0] = 32'h0000_0001; tbl_b[0] = 32'h0000_003F; tbl_exp[0] = 32'h8000_0000;
    tbl_opr[1] = OPR_SRL; tbl_a[1] = 32'h8000_0000; tbl_b[1] = 32'h0000_0004; tbl_exp[1] = 32'h0800_0000;
    tbl_opr[2] = OPR_SLT; tbl_a[2] = 32'hFFFF_FFFF; tbl_b[2] = 32'h0000_0001; tbl_exp[2] = 32'h0000_0001;
    tbl_opr[3] = OPR_ADD; tbl_a[3] = 32'hFFFF_FFFF; tbl_b[3] = 32'h0000_0002; tbl_exp[3] = 32'h0000_0001;
    tbl_opr[4] = OPR_XOR; tbl_a[4] = 32'hF0F0_F0F0; tbl_b[4] = 32'hFFFF_0000; tbl_exp[4] = 32'h0F0F_F0F0;
    tbl_opr[5] = OPR_OR;  tbl_a[5] = 32'hF000_0000; tbl_b[5] = 32'h0000_000F; tbl_exp[5] = 32'hF000_000F;

    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_opr = '0;

    // Reset state, with a request already pending.
    set_op(0, 1'b1, 32'd10, 32'd5, OPR_ADD);
    #2;
    check("rst_valid",  32'(rsp_valid), 32'd0);
    check("rst_id",     32'(rsp_id),    32'd0);
    check("rst_result", rsp_result,     32'd0);
    check("rst_err",    32'(rsp_err),   32'd0);
    check("rst_ops",    ops_done,       32'd0);
    check("rst_ready",  32'(req_ready), 32'd0);
    step; step;
    check("rst_no_accept_valid", 32'(rsp_valid), 32'd0);
    check("rst_no_accept_ops",   ops_done,       32'd0);

    // Single op: ADD 10+5 from req0.
    rst_n = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'b01);
    step;
    set_op(0, 1'b0, 32'd0, 32'd0, OPR_ADD);
    check("single_valid",  32'(rsp_valid), 32'd1);
    check("single_id",     32'(rsp_id),    32'd0);
    check("single_result", rsp_result,     32'd15);
    check("single_err",    32'(rsp_err),   32'd0);
    check("single_ops",    ops_done,       32'd1);
    step;
    check("drain_valid",  32'(rsp_valid), 32'd0);
    check("drain_result", rsp_result,     32'd15);

    // Backpressure: req1 AND accepted, then slot held for 3 cycles.
    rsp_ready = 1'b0;
    set_op(1, 1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, OPR_AND);
    #1;
    check("bp_grant1", 32'(req_ready), 32'b10);
    step;
    set_op(0, 1'b1, 32'd10, 32'd5, OPR_SUB);
    set_op(1, 1'b1, 32'hFFFF_FFF8, 32'd2, OPR_SRA);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid",  32'(rsp_valid), 32'd1);
      check("bp_id",     32'(rsp_id),    32'd1);
      check("bp_result", rsp_result,     32'h0F00_0F00);
      check("bp_ready",  32'(req_ready), 32'b00);
      check("bp_ops",    ops_done,       32'd2);
      step;
    end

    // Contention: both valid every cycle, pointer at 0 -> 0,1,0,1.
    rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("cont_ready", 32'(req_ready), (j % 2 == 0) ? 32'b01 : 32'b10);
      step;
      check("cont_valid",  32'(rsp_valid), 32'd1);
      check("cont_id",     32'(rsp_id),    32'(j % 2));
      check("cont_result", rsp_result,     (j % 2 == 0) ? 32'd5 : 32'hFFFF_FFFE);
      check("cont_ops",    ops_done,       32'(3 + j));
    end
    req_valid = '0;
    step;
    check("cont_drain", 32'(rsp_valid), 32'd0);

    // Illegal opcode, then a legal SLTU straight behind it.
    set_op(0, 1'b1, 32'd123, 32'd456, 4'b1111);
    step;
    set_op(0, 1'b1, 32'hFFFF_FFFF, 32'd1, OPR_SLTU);
    check("illegal_valid",  32'(rsp_valid), 32'd1);
    check("illegal_result", rsp_result,     32'd0);
    check("illegal_err",    32'(rsp_err),   32'd1);
    check("illegal_ops",    ops_done,       32'd7);
    step;
    check("sltu_result", rsp_result,   32'd0);
    check("sltu_err",    32'(rsp_err), 32'd0);
    check("sltu_ops",    ops_done,     32'd8);

    // Remaining opcodes, back to back from req0.
    for (int t = 0; t < 6; t++) begin
      set_op(0, 1'b1, tbl_a[t], tbl_b[t], tbl_opr[t]);
      step;
      check("tbl_result", rsp_result,   tbl_exp[t]);
      check("tbl_err",    32'(rsp_err), 32'd0);
    end
    check("tbl_ops", ops_done, 32'd14);

    // Async reset between edges while a response is held.
    rsp_ready = 1'b0;
    set_op(0, 1'b1, 32'd1, 32'd1, OPR_ADD);
    set_op(1, 1'b1, 32'd1, 32'd1, OPR_ADD);
    #2;
    check("pre_arst_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(rsp_valid), 32'd0);
    check("arst_id",     32'(rsp_id),    32'd0);
    check("arst_result", rsp_result,     32'd0);
    check("arst_err",    32'(rsp_err),   32'd0);
    check("arst_ops",    ops_done,       32'd0);
    check("arst_ready",  32'(req_ready), 32'd0);
    #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("post_arst_ptr0", 32'(req_ready), 32'b01);
    set_op(0, 1'b0, 32'd0, 32'd0, OPR_ADD);
    set_op(1, 1'b1, 32'd7, 32'd3, OPR_SUB);
    #1;
    check("post_arst_req1_only", 32'(req_ready), 32'b10);
    step;
    check("post_arst_id1",     32'(rsp_id), 32'd1);
    check("post_arst_result1", rsp_result,  32'd4);
    check("post_arst_ops1",    ops_done,    32'd1);
    set_op(0, 1'b1, 32'd3, 32'd2, OPR_ADD);
    #1;
    check("post_arst_both", 32'(req_ready), 32'b01);
    step;
    check("post_arst_id0",     32'(rsp_id), 32'd0);
    check("post_arst_result0", rsp_result,  32'd5);
    check("post_arst_ops2",    ops_done,    32'd2);
    req_valid = '0;
    step;

    // Counter wrap via a preset value.
    force dut.ops_done = 32'hFFFF_FFFF;
    #1;
    release dut.ops_done;
    #1;
    check("wrap_preset", ops_done, 32'hFFFF_FFFF);
    set_op(0, 1'b1, 32'd1, 32'd1, OPR_ADD);
    step;
    req_valid = '0;
    check("wrap_ops",    ops_done,   32'd0);
    check("wrap_result", rsp_result, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
